// File: rtl/adc_capture_ctrl.sv
// Triggered ADC capture: arm, wait for trigger, decimate, pack 4x10-bit samples per 40-bit FIFO word.
// Latency: trigger cycle T -> first wren at T+5 (decim=0), then one word per 4*(decim+1) cycles.
// Backpressure: afull in a word's completion cycle drops that word and counts it (no stall, no retry).
// Build option ADC_TEST_PATTERN_EN: sample source becomes a 10-bit ramp restarted on arm.
module adc_capture_ctrl #(
    parameter int DECIM_W = 8,
    parameter int LEN_W   = 16
) (
    input  logic               clk50,
    input  logic               rst_n,
    input  logic [9:0]         idata,
    input  logic               adcovr,
    input  logic               arm,
    input  logic [1:0]         trig_mode,
    input  logic [9:0]         trig_level,
    input  logic               trig_ext,
    input  logic [DECIM_W-1:0] decim,
    input  logic [LEN_W-1:0]   cap_words,
    input  logic               afull,
    output logic [39:0]        odata,
    output logic               wren,
    output logic               busy,
    output logic               done,
    output logic [15:0]        ovf_cnt,
    output logic               ovr_seen
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [9:0]         lvl_q, lvl_d;
    logic [DECIM_W-1:0] decim_q, decim_d;
    logic [DECIM_W-1:0] dcnt_q, dcnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   wcnt_q, wcnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [29:0]        part_q, part_d;
    logic [39:0]        odata_q, odata_d;
    logic               wren_q, wren_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;
    logic [15:0]        ovf_q, ovf_d;
    logic               ovr0_q;

    logic [9:0]         cur_smp;
    logic [9:0]         prev_smp;
    logic               trig;
    logic               accept;
    logic               last_word;

`ifdef ADC_TEST_PATTERN_EN
    logic [9:0] ramp_q, ramp_d;
    logic [9:0] ramp_prev_q;

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            ramp_q      <= '0;
            ramp_prev_q <= '0;
        end else begin
            ramp_q      <= ramp_d;
            ramp_prev_q <= ramp_q;
        end
    end

    assign cur_smp  = ramp_q;
    assign prev_smp = ramp_prev_q;
`else
    logic [9:0] s0_q;
    logic [9:0] s1_q;

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            s0_q <= '0;
            s1_q <= '0;
        end else begin
            s0_q <= idata;
            s1_q <= s0_q;
        end
    end

    assign cur_smp  = s0_q;
    assign prev_smp = s1_q;
`endif

    // Over-range flag registered alongside the sample so it lines up with cur_smp.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            ovr0_q <= 1'b0;
        end else begin
            ovr0_q <= adcovr;
        end
    end

    always_comb begin
        trig = 1'b0;
        case (mode_q)
            2'b00:   trig = 1'b1;
            2'b01:   trig = (prev_smp < lvl_q) && (cur_smp >= lvl_q);
            2'b10:   trig = (prev_smp >= lvl_q) && (cur_smp < lvl_q);
            default: trig = trig_ext;
        endcase
    end

    assign accept    = (state_q == ST_CAPTURE) && (dcnt_q == '0);
    // len_q == 0 wraps to all-ones here, giving the full 2**LEN_W word capture.
    assign last_word = (wcnt_q == (len_q - LEN_W'(1)));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lvl_d   = lvl_q;
        decim_d = decim_q;
        len_d   = len_q;
        dcnt_d  = dcnt_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        part_d  = part_q;
        odata_d = odata_q;
        ovf_d   = ovf_q;
        ovr_d   = ovr_q;
        wren_d  = 1'b0;
        done_d  = 1'b0;
`ifdef ADC_TEST_PATTERN_EN
        ramp_d  = ramp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_ARMED;
                    mode_d  = trig_mode;
                    lvl_d   = trig_level;
                    decim_d = decim;
                    len_d   = cap_words;
                    dcnt_d  = '0;
                    wcnt_d  = '0;
                    idx_d   = '0;
                    part_d  = '0;
                    ovf_d   = '0;
                    ovr_d   = 1'b0;
`ifdef ADC_TEST_PATTERN_EN
                    ramp_d  = '0;
`endif
                end
            end
            ST_ARMED: begin
                if (trig) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + DECIM_W'(1);
                if (accept) begin
                    ovr_d = ovr_q | ovr0_q;
                    idx_d = idx_q + 2'd1;
`ifdef ADC_TEST_PATTERN_EN
                    ramp_d = ramp_q + 10'd1;
`endif
                    case (idx_q)
                        2'd0: part_d[9:0]   = cur_smp;
                        2'd1: part_d[19:10] = cur_smp;
                        2'd2: part_d[29:20] = cur_smp;
                        default: begin
                            wcnt_d = wcnt_q + LEN_W'(1);
                            if (afull) begin
                                ovf_d = (ovf_q == 16'hFFFF) ? ovf_q : ovf_q + 16'd1;
                            end else begin
                                wren_d  = 1'b1;
                                odata_d = {cur_smp, part_q};
                            end
                            if (last_word) begin
                                state_d = ST_DONE;
                            end
                        end
                    endcase
                end
            end
            default: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            lvl_q   <= '0;
            decim_q <= '0;
            len_q   <= '0;
            dcnt_q  <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            part_q  <= '0;
            odata_q <= '0;
            ovf_q   <= '0;
            ovr_q   <= 1'b0;
            wren_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lvl_q   <= lvl_d;
            decim_q <= decim_d;
            len_q   <= len_d;
            dcnt_q  <= dcnt_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            part_q  <= part_d;
            odata_q <= odata_d;
            ovf_q   <= ovf_d;
            ovr_q   <= ovr_d;
            wren_q  <= wren_d;
            done_q  <= done_d;
        end
    end

    assign odata    = odata_q;
    assign wren     = wren_q;
    assign done     = done_q;
    assign busy     = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign ovf_cnt  = ovf_q;
    assign ovr_seen = ovr_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: expected words are built from the input pattern when a capture is started.
module tb_adc_capture_ctrl;

    logic        clk50 = 1'b0;
    logic        rst_n;
    logic [9:0]  idata;
    logic        adcovr;
    logic        arm;
    logic [1:0]  trig_mode;
    logic [9:0]  trig_level;
    logic        trig_ext;
    logic [7:0]  decim;
    logic [15:0] cap_words;
    logic        afull;
    logic [39:0] odata;
    logic        wren;
    logic        busy;
    logic        done;
    logic [15:0] ovf_cnt;
    logic        ovr_seen;

    adc_capture_ctrl #(.DECIM_W(8), .LEN_W(16)) dut (
        .clk50(clk50), .rst_n(rst_n), .idata(idata), .adcovr(adcovr), .arm(arm),
        .trig_mode(trig_mode), .trig_level(trig_level), .trig_ext(trig_ext),
        .decim(decim), .cap_words(cap_words), .afull(afull), .odata(odata),
        .wren(wren), .busy(busy), .done(done), .ovf_cnt(ovf_cnt), .ovr_seen(ovr_seen)
    );

    always #10 clk50 = ~clk50;

    // ecnt == c during clock cycle c (the period after rising edge c).
    int ecnt = 0;
    always @(posedge clk50) ecnt <= ecnt + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int pmode     = 0;
    int base      = 0;
    int afull_all = 0;
    int afull_cyc = -1;
    int ext_cyc   = -1;
    int ext_cyc2  = -1;
    int ovr_cyc   = -1;

    // Sample value registered into the DUT at edge e.
    function automatic logic [9:0] pat(input int e);
        case (pmode)
            0:       return 10'((e * 37 + 11) % 1024);
            1:       return (e < base) ? 10'd0 : 10'(490 + (e - base) / 2);
            default: return 10'h2A5;
        endcase
    endfunction

    function automatic logic [9:0] smp(input int e, input int m);
        logic [9:0] r;
        r = 10'(m);
`ifndef ADC_TEST_PATTERN_EN
        r = pat(e);
`endif
        return r;
    endfunction

    task automatic drive();
        idata    = pat(ecnt + 1);
        adcovr   = (ecnt + 1 == ovr_cyc);
        afull    = (afull_all != 0) || (ecnt == afull_cyc);
        trig_ext = (ecnt == ext_cyc) || (ecnt == ext_cyc2);
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
        drive();
    endtask

    logic [39:0] expq[$];
    int wren_cnt   = 0;
    int first_wren = -1;
    int last_wren  = -1;

    always @(negedge clk50) begin
        if (rst_n === 1'b1 && wren === 1'b1) begin
            wren_cnt++;
            last_wren = ecnt;
            if (first_wren < 0) first_wren = ecnt;
            if (expq.size() == 0) chk("wren_unexpected", 40'd1, 40'd0);
            else chk("odata", odata, expq.pop_front());
        end
    end

    // Trigger taken in cycle t: slot m is the sample registered in cycle t+1+m*(d+1).
    task automatic push_words(input int t, input int d, input int nw, input int skip);
        logic [39:0] w;
        for (int j = 0; j < nw; j++) begin
            for (int k = 0; k < 4; k++) w[10*k +: 10] = smp(t + 1 + (4*j + k) * (d + 1), 4*j + k);
            if (j != skip) expq.push_back(w);
        end
    endtask

    task automatic clr();
        wren_cnt   = 0;
        first_wren = -1;
        last_wren  = -1;
    endtask

    task automatic start(input logic [1:0] m, input logic [9:0] lvl, input logic [7:0] d, input logic [15:0] cw);
        trig_mode  = m;
        trig_level = lvl;
        decim      = d;
        cap_words  = cw;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int de);
        de = -1;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (done === 1'b1) begin
                de = ecnt;
                break;
            end
        end
        if (de < 0) chk("done_timeout", 40'd0, 40'd1);
    endtask

    function automatic int find_rise(input int from, input logic [9:0] lvl);
        for (int e = from; e < from + 3000; e++)
            if (pat(e - 1) < lvl && pat(e) >= lvl) return e;
        return -1;
    endfunction

    int n, t, de;

    initial begin
        rst_n = 1'b0; arm = 1'b0; trig_mode = 2'b00; trig_level = '0; decim = '0; cap_words = '0;
        drive();
        repeat (3) tick();
        chk("rst_odata", odata, 40'd0);
        chk("rst_wren", 40'(wren), 40'd0);
        chk("rst_busy", 40'(busy), 40'd0);
        chk("rst_done", 40'(done), 40'd0);
        chk("rst_ovf", 40'(ovf_cnt), 40'd0);
        chk("rst_ovr", 40'(ovr_seen), 40'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Immediate trigger, two words; config changes after arming must be ignored.
        clr(); pmode = 0; drive();
        n = ecnt + 1; t = n;
        push_words(t, 0, 2, -1);
        start(2'b00, 10'd0, 8'd0, 16'd2);
        chk("t1_busy_armed", 40'(busy), 40'd1);
        decim = 8'd5; cap_words = 16'd7; trig_mode = 2'b11;
        wait_done(60, de);
        chk("t1_wren_cnt", 40'(wren_cnt), 40'd2);
        chk("t1_first_wren", 40'(first_wren), 40'(t + 5));
        chk("t1_done_after_wren", 40'(de), 40'(last_wren + 1));
        chk("t1_busy_done", 40'(busy), 40'd0);
        tick();
        chk("t1_done_pulse", 40'(done), 40'd0);

`ifndef ADC_TEST_PATTERN_EN
        // Rising level trigger at 500 on a slow ramp.
        clr(); pmode = 1; base = ecnt + 1; drive();
        n = ecnt + 1; t = find_rise(n, 10'd500);
        push_words(t, 0, 1, -1);
        start(2'b01, 10'd500, 8'd0, 16'd1);
        wait_done(100, de);
        chk("t2_first_wren", 40'(first_wren), 40'(t + 5));
        chk("t2_slot0", 40'(odata[9:0]), 40'd500);
        chk("t2_wren_cnt", 40'(wren_cnt), 40'd1);
`endif

        // decim=3, single word: wren 13 cycles after entering CAPTURE (t+1).
        clr(); pmode = 2; drive();
        n = ecnt + 1; t = n;
        push_words(t, 3, 1, -1);
        start(2'b00, 10'd0, 8'd3, 16'd1);
        wait_done(100, de);
        chk("t3_wren_lat", 40'(first_wren), 40'(t + 1 + 13));
        chk("t3_wren_cnt", 40'(wren_cnt), 40'd1);

        // afull throughout: every word dropped and counted.
        clr(); pmode = 0; afull_all = 1; drive();
        start(2'b00, 10'd0, 8'd0, 16'd5);
        wait_done(100, de);
        chk("t4_wren_cnt", 40'(wren_cnt), 40'd0);
        chk("t4_ovf", 40'(ovf_cnt), 40'd5);
        afull_all = 0; drive();
        clr(); n = ecnt + 1; t = n;
        push_words(t, 0, 1, -1);
        start(2'b00, 10'd0, 8'd0, 16'd1);
        chk("t4_ovf_cleared", 40'(ovf_cnt), 40'd0);
        wait_done(60, de);
        chk("t4_rearm_wren", 40'(wren_cnt), 40'd1);

        // afull only in the middle word's completion cycle.
        clr(); n = ecnt + 1; t = n; afull_cyc = t + 8;
        push_words(t, 0, 3, 1);
        drive();
        start(2'b00, 10'd0, 8'd0, 16'd3);
        wait_done(80, de);
        chk("t4b_wren_cnt", 40'(wren_cnt), 40'd2);
        chk("t4b_ovf", 40'(ovf_cnt), 40'd1);
        afull_cyc = -1;

        // External trigger, then async reset mid-capture.
        clr(); pmode = 0; n = ecnt + 1; t = n + 2; ext_cyc = t; ext_cyc2 = t + 3;
        push_words(t, 0, 1, -1);
        drive();
        start(2'b11, 10'd0, 8'd0, 16'd4);
        chk("t5_no_early_cap", 40'(busy), 40'd1);
        while (ecnt < t + 6) tick();
        chk("t5_word0", 40'(wren_cnt), 40'd1);
        chk("t5_busy_cap", 40'(busy), 40'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_wren", 40'(wren), 40'd0);
        chk("t5_rst_odata", odata, 40'd0);
        chk("t5_rst_busy", 40'(busy), 40'd0);
        chk("t5_rst_done", 40'(done), 40'd0);
        chk("t5_rst_ovf", 40'(ovf_cnt), 40'd0);
        chk("t5_rst_ovr", 40'(ovr_seen), 40'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        ext_cyc = ecnt + 4; ext_cyc2 = -1;
        repeat (20) tick();
        chk("t5_no_wren_after", 40'(wren_cnt), 40'd1);
        chk("t5_idle", 40'(busy), 40'd0);
        ext_cyc = -1;

        // adcovr on a skipped sample, then on an accepted one.
        clr(); pmode = 2; n = ecnt + 1; t = n; ovr_cyc = t + 2;
        push_words(t, 1, 1, -1);
        drive();
        start(2'b00, 10'd0, 8'd1, 16'd1);
        wait_done(60, de);
        chk("t6_ovr_skipped", 40'(ovr_seen), 40'd0);
        clr(); n = ecnt + 1; t = n; ovr_cyc = t + 3;
        push_words(t, 1, 1, -1);
        drive();
        start(2'b00, 10'd0, 8'd1, 16'd1);
        wait_done(60, de);
        chk("t6_ovr_accepted", 40'(ovr_seen), 40'd1);
        ovr_cyc = -1;
        repeat (3) tick();
        chk("t6_ovr_sticky", 40'(ovr_seen), 40'd1);
        clr(); n = ecnt + 1; t = n;
        push_words(t, 0, 1, -1);
        start(2'b00, 10'd0, 8'd0, 16'd1);
        chk("t6_ovr_cleared", 40'(ovr_seen), 40'd0);
        wait_done(60, de);

        repeat (3) tick();
        chk("queue_empty", 40'(expq.size()), 40'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
